// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven master and its slave.
// Protection signals are absent; the slave side ties them off.
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one user command into one
// AXI4-Lite read or write and returns the completion on the rsp_* port.
// All VALID/READY outputs toward the bus and rsp_valid are registered.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4_lite_master_if.master      axi
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [DATA_WIDTH-1:0]   hold_wdata;
  logic [DATA_WIDTH/8-1:0] hold_wstrb;
  logic                    hold_write;
  logic                    aw_done, w_done;

  logic cmd_fire, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_req_done;

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;

  // handshakes are qualified by state so early VALIDs from the slave are ignored
  assign aw_hs = (state == WR_REQ)  & axi.awvalid & axi.awready;
  assign w_hs  = (state == WR_REQ)  & axi.wvalid  & axi.wready;
  assign b_hs  = (state == WR_RESP) & axi.bvalid  & axi.bready;
  assign ar_hs = (state == RD_REQ)  & axi.arvalid & axi.arready;
  assign r_hs  = (state == RD_RESP) & axi.rvalid  & axi.rready;

  // AW and W may complete on the same cycle or in either order
  assign wr_req_done = (aw_done | aw_hs) & (w_done | w_hs);

  // the holding registers drive the bus directly, keeping it stable under VALID
  assign axi.awaddr = hold_addr;
  assign axi.araddr = hold_addr;
  assign axi.wdata  = hold_wdata;
  assign axi.wstrb  = hold_wstrb;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire)    state_next = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (wr_req_done) state_next = WR_RESP;
      WR_RESP: if (b_hs)        state_next = DONE;
      RD_REQ:  if (ar_hs)       state_next = RD_RESP;
      RD_RESP: if (r_hs)        state_next = DONE;
      DONE:    if (rsp_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // registered bus controls, holding registers and completion capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr   <= '0;
      hold_wdata  <= '0;
      hold_wstrb  <= '0;
      hold_write  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            hold_addr   <= cmd_addr;
            hold_wdata  <= cmd_wdata;
            hold_wstrb  <= cmd_wstrb;
            hold_write  <= cmd_write;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi.awvalid <= cmd_write;
            axi.wvalid  <= cmd_write;
            axi.arvalid <= ~cmd_write;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (wr_req_done) axi.bready <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            axi.bready <= 1'b0;
            rsp_resp   <= axi.bresp;
            rsp_rdata  <= '0;
            rsp_write  <= hold_write;
            rsp_valid  <= 1'b1;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            axi.rready <= 1'b0;
            rsp_rdata  <= axi.rdata;
            rsp_resp   <= axi.rresp;
            rsp_write  <= hold_write;
            rsp_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-programmable AXI4-Lite slave, a table of
// transactions with expected completion/timing, and a few hand-written
// sequences for back-pressure on the response port and mid-transaction reset.
module tb_axi4_lite_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axi4_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic        b_early;
    logic [1:0]  slv_resp;
    logic [31:0] slv_rdata;
    int          exp_lat, exp_aw, exp_w, exp_ar, exp_rdy;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration, set by the main thread between transactions
  int          cur_aw_d, cur_w_d, cur_b_d, cur_ar_d, cur_r_d;
  logic        cur_b_early;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model: each READY/VALID goes high after a programmed number of cycles
  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
      end else begin
        axi.awready = axi.awvalid && (aw_wait >= cur_aw_d);
        aw_wait     = axi.awvalid ? aw_wait + 1 : 0;
        axi.wready  = axi.wvalid && (w_wait >= cur_w_d);
        w_wait      = axi.wvalid ? w_wait + 1 : 0;
        axi.arready = axi.arvalid && (ar_wait >= cur_ar_d);
        ar_wait     = axi.arvalid ? ar_wait + 1 : 0;
        if (cur_b_early) begin
          // BVALID already high during the request phase, carrying a poison code
          axi.bvalid = 1'b1;
          axi.bresp  = axi.bready ? cur_resp : 2'b11;
        end else begin
          axi.bvalid = axi.bready && (b_wait >= cur_b_d);
          axi.bresp  = axi.bvalid ? cur_resp : 2'b00;
        end
        b_wait      = axi.bready ? b_wait + 1 : 0;
        axi.rvalid  = axi.rready && (r_wait >= cur_r_d);
        axi.rdata   = axi.rvalid ? cur_rdata : 32'h0;
        axi.rresp   = axi.rvalid ? cur_resp : 2'b00;
        r_wait      = axi.rready ? r_wait + 1 : 0;
      end
    end
  end

  task automatic set_slave(input vec_t v);
    cur_aw_d = v.aw_d; cur_w_d = v.w_d; cur_b_d = v.b_d;
    cur_ar_d = v.ar_d; cur_r_d = v.r_d; cur_b_early = v.b_early;
    cur_resp = v.slv_resp; cur_rdata = v.slv_rdata;
  endtask

  // one transaction; entered and left on a negedge with the DUT idle
  task automatic run_row(input string tag, input vec_t v, input int hold);
    int cyc, k, aw_n, w_n, ar_n, rdy_first, viol, unstable, busy, leak;
    exp_t e;
    logic        s_write;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    set_slave(v);
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    sb.push_back('{v.write, v.exp_rdata, v.exp_resp});
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; aw_n = 0; w_n = 0; ar_n = 0; rdy_first = 0; viol = 0;
    while (cyc <= 60) begin
      aw_n += int'(axi.awvalid);
      w_n  += int'(axi.wvalid);
      ar_n += int'(axi.arvalid);
      if ((axi.bready || axi.rready) && rdy_first == 0) rdy_first = cyc;
      if ((axi.awvalid && axi.awaddr !== v.addr) ||
          (axi.wvalid && (axi.wdata !== v.wdata || axi.wstrb !== v.wstrb)) ||
          (axi.arvalid && axi.araddr !== v.addr))
        viol++;
      if (rsp_valid) break;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
    check({tag, " aw cycles"}, 32'(aw_n), 32'(v.exp_aw));
    check({tag, " w cycles"}, 32'(w_n), 32'(v.exp_w));
    check({tag, " ar cycles"}, 32'(ar_n), 32'(v.exp_ar));
    check({tag, " resp-ready cycle"}, 32'(rdy_first), 32'(v.exp_rdy));
    check({tag, " bus stable"}, 32'(viol), 32'd0);
    e = sb.pop_front();
    check({tag, " rsp_write"}, 32'(rsp_write), 32'(e.write));
    check({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
    check({tag, " rsp_resp"}, 32'(rsp_resp), 32'(e.resp));
    if (hold > 0) begin
      s_write = rsp_write; s_rdata = rsp_rdata; s_resp = rsp_resp;
      unstable = 0; busy = 0; leak = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hFFFF_0000;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_write !== s_write || rsp_rdata !== s_rdata || rsp_resp !== s_resp)
          unstable++;
        busy += int'(cmd_ready);
        leak += int'(axi.awvalid || axi.wvalid || axi.arvalid);
      end
      cmd_valid = 1'b0;
      check({tag, " rsp held stable"}, 32'(unstable), 32'd0);
      check({tag, " cmd_ready low in done"}, 32'(busy), 32'd0);
      check({tag, " no accept in done"}, 32'(leak), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drops"}, 32'(rsp_valid), 32'd0);
    check({tag, " back to idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int leak;
    vec_t v;
    //            wr    addr          wdata         strb   aw w b ar r early resp   rdata         lat aw w ar rdy exp_rdata     exp_resp
    vecs[0] = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0,        3, 1, 1, 0, 2, 32'h0,        2'b00};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0,        6, 4, 1, 0, 5, 32'h0,        2'b00};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h3, 0, 2, 1, 0, 0, 1'b0, 2'b10, 32'h0,        6, 1, 3, 0, 4, 32'h0,        2'b10};
    vecs[3] = '{1'b1, 32'h0000_0003, 32'hA5A5_A5A5, 4'h5, 2, 2, 0, 0, 0, 1'b0, 2'b11, 32'h0,        5, 3, 3, 0, 4, 32'h0,        2'b11};
    vecs[4] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 0, 0, 0, 0, 5, 1'b0, 2'b00, 32'h1234_5678, 8, 0, 0, 1, 2, 32'h1234_5678, 2'b00};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 0, 2, 0, 1'b0, 2'b10, 32'hA5A5_0001, 5, 0, 0, 3, 4, 32'hA5A5_0001, 2'b10};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b11, 32'h0BAD_F00D, 3, 0, 0, 1, 2, 32'h0BAD_F00D, 2'b11};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 4'h8, 0, 0, 0, 0, 0, 1'b1, 2'b01, 32'h0,        3, 1, 1, 0, 2, 32'h0,        2'b01};

    set_slave(vecs[0]);
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 32'd0);
    check("reset bus", axi.awaddr | axi.araddr | axi.wdata | 32'(axi.wstrb), 32'd0);
    check("reset rsp", rsp_rdata | 32'({rsp_resp, rsp_write}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_row($sformatf("row%0d", i), vecs[i], 0);

    // completion back-pressured for 10 cycles with a competing command pending
    run_row("hold", vecs[5], 10);

    // reset while AWVALID is high: transaction abandoned, no completion
    v = vecs[1];
    v.aw_d = 5;
    set_slave(v);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_2000;
    cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid awvalid before reset", 32'(axi.awvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}), 32'd0);
    check("mid reset awaddr", axi.awaddr, 32'd0);
    check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post reset cmd_ready", 32'(cmd_ready), 32'd1);
    leak = 0;
    for (int i = 0; i < 8; i++) begin
      leak += int'(rsp_valid || axi.awvalid || axi.wvalid || axi.bready);
      @(negedge clk);
    end
    check("post reset quiet", 32'(leak), 32'd0);
    run_row("after reset", vecs[0], 0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
